// File: rtl/gpout_router_pkg.sv
// gpout_router_pkg: shared types and helpers for the gpout router and its serial config receiver.
package gpout_router_pkg;
    localparam int DEF_SEL_W = 6;
    typedef struct packed {
        logic                 oeb;
        logic [DEF_SEL_W-1:0] sel;
    } cfg_ch_t;
    function automatic int frame_bits(input int n_ch, input int sel_w);
        return n_ch * (sel_w + 1);
    endfunction
    function automatic int default_sel(input int ch, input int n_src);
        return ch % n_src;
    endfunction
endpackage

// File: rtl/gpout_router_cfg_serial_rx.sv
// gpout_router_cfg_serial_rx: synchronises the 3-wire config port and shifts in whole routing frames.
module gpout_router_cfg_serial_rx
    import gpout_router_pkg::*;
#(
    parameter int N_CH        = 6,
    parameter int SEL_W       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_cfg_sclk,
    input  logic                        i_cfg_mosi,
    input  logic                        i_cfg_csb,
    input  logic                        i_la_invalid,
    output logic                        o_frame_valid,
    output logic                        o_frame_err,
    output logic [N_CH*(SEL_W+1)-1:0]   o_frame_data
);
    localparam int FB = frame_bits(N_CH, SEL_W);
    localparam int CW = $clog2(FB + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FB);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FB + 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_csb_sync;
    logic                   r_sclk_d, r_csb_d;
    logic [CW-1:0]          r_cnt;
    logic [FB-1:0]          r_shift;
    logic                   w_sclk, w_mosi, w_csb, w_sclk_rise, w_csb_rise, w_csb_fall;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_csb       = r_csb_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_csb_rise  = w_csb & ~r_csb_d;
    assign w_csb_fall  = ~w_csb & r_csb_d;

    // Counter parks at CNT_SAT on overflow or abort so the closing csb edge reports an error.
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_csb_sync  <= '1;
            r_sclk_d    <= 1'b0;
            r_csb_d     <= 1'b1;
            r_cnt       <= '0;
            r_shift     <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_cfg_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_cfg_mosi};
            r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], i_cfg_csb};
            r_sclk_d    <= w_sclk;
            r_csb_d     <= w_csb;
            if (i_la_invalid)
                r_cnt <= CNT_SAT;
            else if (w_csb_fall)
                r_cnt <= '0;
            else if (w_sclk_rise && !w_csb) begin
                r_shift <= {r_shift[FB-2:0], w_mosi};
                if (r_cnt != CNT_SAT)
                    r_cnt <= r_cnt + 1'b1;
            end
        end

    assign o_frame_valid = w_csb_rise && !i_la_invalid && (r_cnt == CNT_FULL);
    assign o_frame_err   = w_csb_rise && !i_la_invalid && (r_cnt != CNT_FULL);
    assign o_frame_data  = r_shift;
endmodule

// File: rtl/gpout_router.sv
// gpout_router: routes selectable sources to N_CH pads with per-channel OE,
// using a serially loaded shadow config that is applied on a commit event.
module gpout_router
    import gpout_router_pkg::*;
#(
    parameter int N_CH        = 6,
    parameter int N_SRC       = 64,
    parameter int SEL_W       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_SRC-1:0]  i_src,
    input  logic              i_cfg_sclk,
    input  logic              i_cfg_mosi,
    input  logic              i_cfg_csb,
    input  logic              i_la_invalid,
    input  logic              i_commit_evt,
    input  logic              i_commit_now,
    output logic [N_CH-1:0]   o_gpout,
    output logic [N_CH-1:0]   o_gpout_oeb,
    output logic              o_cfg_pending,
    output logic              o_cfg_err
);
    localparam int FB = frame_bits(N_CH, SEL_W);
    localparam logic [SEL_W:0] SRC_LIM = (SEL_W+1)'(N_SRC);

    logic             w_frame_valid, w_frame_err, w_commit;
    logic [FB-1:0]    w_frame_data;
    logic [SEL_W-1:0] r_shd_sel [N_CH];
    logic [SEL_W-1:0] r_act_sel [N_CH];
    logic [N_CH-1:0]  r_shd_oeb, r_act_oeb, w_mux, r_gpout, r_gpout_oeb;
    logic             r_pending, r_err, r_commit_d;

    gpout_router_cfg_serial_rx #(
        .N_CH(N_CH), .SEL_W(SEL_W), .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cfg_sclk(i_cfg_sclk), .i_cfg_mosi(i_cfg_mosi), .i_cfg_csb(i_cfg_csb),
        .i_la_invalid(i_la_invalid),
        .o_frame_valid(w_frame_valid), .o_frame_err(w_frame_err), .o_frame_data(w_frame_data)
    );

    assign w_commit = r_pending && ((i_commit_evt && !r_commit_d) || i_commit_now);

    // Commit reads the shadow before a same-cycle frame overwrites it, so the new frame stays pending.
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_shd_sel[i] <= SEL_W'(default_sel(i, N_SRC));
                r_act_sel[i] <= SEL_W'(default_sel(i, N_SRC));
            end
            r_shd_oeb  <= '0;
            r_act_oeb  <= '0;
            r_pending  <= 1'b0;
            r_err      <= 1'b0;
            r_commit_d <= 1'b0;
        end else begin
            r_commit_d <= i_commit_evt;
            if (w_commit) begin
                r_act_sel <= r_shd_sel;
                r_act_oeb <= r_shd_oeb;
                r_pending <= 1'b0;
            end
            if (w_frame_valid) begin
                for (int i = 0; i < N_CH; i++) begin
                    r_shd_sel[i] <= w_frame_data[i*(SEL_W+1) +: SEL_W];
                    r_shd_oeb[i] <= w_frame_data[i*(SEL_W+1) + SEL_W];
                end
                r_pending <= 1'b1;
                r_err     <= 1'b0;
            end else if (w_frame_err)
                r_err <= 1'b1;
        end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign w_mux[c] = ({1'b0, r_act_sel[c]} < SRC_LIM) ? i_src[r_act_sel[c]] : 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            r_gpout     <= '0;
            r_gpout_oeb <= '0;
        end else begin
            r_gpout     <= w_mux;
            r_gpout_oeb <= r_act_oeb;
        end

    assign o_gpout       = r_gpout;
    assign o_gpout_oeb   = r_gpout_oeb;
    assign o_cfg_pending = r_pending;
    assign o_cfg_err     = r_err;
endmodule
